// File: rtl/mux_2to1_sel_pkg.sv
// Shared constants for the mux_2to1_sel operand selector: default width,
// selector encodings and the width of the selector-toggle statistics counter.
package mux_2to1_sel_pkg;

   localparam int   NB_DATA_DEF = 32;
   localparam logic SEL_IN0     = 1'b0;
   localparam logic SEL_IN1     = 1'b1;
   localparam int   CNT_W       = 16;

endpackage

// File: rtl/mux_2to1_sel_if.sv
// Data/qualifier bundle for mux_2to1_sel. o_sel_toggles exists only when
// MUX_SEL_STATS_EN is defined.
interface mux_2to1_sel_if
   import mux_2to1_sel_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF
);
   logic               i_enable;
   logic               i_valid;
   logic               i_selector;
   logic [NB_DATA-1:0] i_entradaMUX_0;
   logic [NB_DATA-1:0] i_entradaMUX_1;
   logic [NB_DATA-1:0] o_salidaMUX;
   logic               o_valid;
`ifdef MUX_SEL_STATS_EN
   logic [CNT_W-1:0]   o_sel_toggles;
`endif

   modport master (
      output i_enable, i_valid, i_selector, i_entradaMUX_0, i_entradaMUX_1,
`ifdef MUX_SEL_STATS_EN
      input  o_sel_toggles,
`endif
      input  o_salidaMUX, o_valid
   );

   modport slave (
      input  i_enable, i_valid, i_selector, i_entradaMUX_0, i_entradaMUX_1,
`ifdef MUX_SEL_STATS_EN
      output o_sel_toggles,
`endif
      output o_salidaMUX, o_valid
   );

endinterface

// File: rtl/mux_2to1_sel_out_reg.sv
// Load-enable register with asynchronous active-low clear; holds the
// selected word together with its valid flag.
module mux_2to1_sel_out_reg #(
   parameter int W = 33
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_en,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         o_q <= '0;
      else if (i_en)
         o_q <= i_d;
   end

endmodule

// File: rtl/mux_2to1_sel.sv
// Two-input word selector with optional output register (REGISTERED) and
// optional selector-toggle counter (build macro MUX_SEL_STATS_EN).
module mux_2to1_sel
   import mux_2to1_sel_pkg::*;
#(
   parameter int NB_DATA    = NB_DATA_DEF,
   parameter bit REGISTERED = 1'b1
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   mux_2to1_sel_if.slave  bus
);

   logic [NB_DATA-1:0] sel_data;

   // An X/Z selector propagates X rather than defaulting to either leg.
   assign sel_data = (bus.i_selector == SEL_IN1) ? bus.i_entradaMUX_1
                                                 : bus.i_entradaMUX_0;

   generate
      if (REGISTERED) begin : g_reg
         logic [NB_DATA:0] q;

         mux_2to1_sel_out_reg #(
            .W (NB_DATA + 1)
         ) u_out_reg (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_en    (bus.i_enable),
            .i_d     ({bus.i_valid, sel_data}),
            .o_q     (q)
         );

         assign bus.o_valid     = q[NB_DATA];
         assign bus.o_salidaMUX = q[NB_DATA-1:0];
      end else begin : g_comb
         assign bus.o_valid     = bus.i_valid;
         assign bus.o_salidaMUX = sel_data;
      end
   endgenerate

`ifdef MUX_SEL_STATS_EN
   logic             prev_sel;
   logic [CNT_W-1:0] sel_toggles;

   // Only qualified edges update the reference selector and the count.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         prev_sel    <= SEL_IN0;
         sel_toggles <= '0;
      end else if (bus.i_valid) begin
         prev_sel <= bus.i_selector;
         if ((bus.i_selector != prev_sel) && (sel_toggles != '1))
            sel_toggles <= sel_toggles + 1'b1;
      end
   end

   assign bus.o_sel_toggles = sel_toggles;
`endif

endmodule

// File: tb/tb_mux_2to1_sel.sv
// Self-checking bench for mux_2to1_sel: one registered and one combinational
// instance driven from the same stimulus, compared to a behavioural model.
module tb_mux_2to1_sel;
   import mux_2to1_sel_pkg::*;

   localparam int NB = 32;
   localparam logic [NB-1:0] A = 32'hfff000aa;
   localparam logic [NB-1:0] B = 32'hffffffff;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          en, val, sel;
   logic [NB-1:0] d0, d1;

   int n_checks = 0;
   int n_errors = 0;

   logic [NB-1:0] exp_data;
   logic          exp_valid;
   int            exp_tog;
   logic          exp_prev;

   always #5 i_clk = ~i_clk;

   mux_2to1_sel_if #(.NB_DATA(NB)) bus_r ();
   mux_2to1_sel_if #(.NB_DATA(NB)) bus_c ();

   assign bus_r.i_enable       = en;
   assign bus_r.i_valid        = val;
   assign bus_r.i_selector     = sel;
   assign bus_r.i_entradaMUX_0 = d0;
   assign bus_r.i_entradaMUX_1 = d1;
   assign bus_c.i_enable       = en;
   assign bus_c.i_valid        = val;
   assign bus_c.i_selector     = sel;
   assign bus_c.i_entradaMUX_0 = d0;
   assign bus_c.i_entradaMUX_1 = d1;

   mux_2to1_sel #(.NB_DATA(NB), .REGISTERED(1'b1)) dut_reg (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus_r)
   );

   mux_2to1_sel #(.NB_DATA(NB), .REGISTERED(1'b0)) dut_comb (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus_c)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_stats(input string tag);
`ifdef MUX_SEL_STATS_EN
      chk({tag, "_tog_r"}, 64'(bus_r.o_sel_toggles), 64'(exp_tog));
      chk({tag, "_tog_c"}, 64'(bus_c.o_sel_toggles), 64'(exp_tog));
`else
      n_checks += 0;
`endif
   endtask

   // Drive one cycle of inputs, check the combinational instance at once,
   // then advance one edge and check the registered instance and counters.
   task automatic cycle(input logic e, input logic v, input logic s,
                        input logic [NB-1:0] a, input logic [NB-1:0] b);
      en = e; val = v; sel = s; d0 = a; d1 = b;
      #1;
      chk("comb_data",  64'(bus_c.o_salidaMUX), 64'(s ? b : a));
      chk("comb_valid", 64'(bus_c.o_valid),     64'(v));
      if (e) begin
         exp_data  = s ? b : a;
         exp_valid = v;
      end
      if (v) begin
         if (s != exp_prev && exp_tog < 65535) exp_tog++;
         exp_prev = s;
      end
      @(posedge i_clk);
      #1;
      chk("reg_data",  64'(bus_r.o_salidaMUX), 64'(exp_data));
      chk("reg_valid", 64'(bus_r.o_valid),     64'(exp_valid));
      chk_stats("cyc");
   endtask

   // Reset asserted between edges must clear the registered outputs at once.
   task automatic do_reset();
      i_rst_n = 1'b0;
      en = 1'b1; val = 1'b1; sel = 1'b1; d0 = A; d1 = B;
      exp_data = '0; exp_valid = 1'b0; exp_tog = 0; exp_prev = 1'b0;
      #1;
      chk("rst_data",  64'(bus_r.o_salidaMUX), 64'd0);
      chk("rst_valid", 64'(bus_r.o_valid),     64'd0);
      chk("rst_comb",  64'(bus_c.o_salidaMUX), 64'(B));
      chk_stats("rst");
      @(posedge i_clk);
      #1;
      chk("rst_hold_data",  64'(bus_r.o_salidaMUX), 64'd0);
      chk("rst_hold_valid", 64'(bus_r.o_valid),     64'd0);
      i_rst_n = 1'b1;
   endtask

   initial begin
      i_rst_n = 1'b1;
      en = 1'b0; val = 1'b0; sel = 1'b0; d0 = A; d1 = B;
      exp_data = '0; exp_valid = 1'b0; exp_tog = 0; exp_prev = 1'b0;
      @(posedge i_clk);
      #1;
      do_reset();

      // select input 0
      cycle(1'b1, 1'b1, 1'b0, A, B);
      chk("sel0_data", 64'(bus_r.o_salidaMUX), 64'(A));

      // toggle sequence, each selector value held two cycles
      cycle(1'b1, 1'b1, 1'b1, A, B);
      chk("tog1_data", 64'(bus_r.o_salidaMUX), 64'(B));
      cycle(1'b1, 1'b1, 1'b1, A, B);
      cycle(1'b1, 1'b1, 1'b0, A, B);
      chk("tog0_data", 64'(bus_r.o_salidaMUX), 64'(A));
      cycle(1'b1, 1'b1, 1'b0, A, B);

      // hold with enable low, then re-enable
      cycle(1'b0, 1'b1, 1'b1, A, B);
      chk("hold_data", 64'(bus_r.o_salidaMUX), 64'(A));
      cycle(1'b1, 1'b1, 1'b1, A, B);
      chk("reen_data", 64'(bus_r.o_salidaMUX), B);

      // invalid data still passes, only the flag drops
      cycle(1'b1, 1'b0, 1'b0, A, B);
      chk("inval_data",  64'(bus_r.o_salidaMUX), 64'(A));
      chk("inval_valid", 64'(bus_r.o_valid),     64'd0);

      // statistics: 5 qualified changes plus one unqualified change
      do_reset();
      cycle(1'b1, 1'b1, 1'b1, A, B);
      cycle(1'b1, 1'b1, 1'b0, A, B);
      cycle(1'b1, 1'b1, 1'b1, A, B);
      cycle(1'b1, 1'b1, 1'b0, A, B);
      cycle(1'b1, 1'b1, 1'b1, A, B);
      cycle(1'b1, 1'b0, 1'b0, A, B);
`ifdef MUX_SEL_STATS_EN
      chk("stats5", 64'(bus_r.o_sel_toggles), 64'd5);
`endif
      do_reset();

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 39) == 0)
            do_reset();
         cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
               NB'($urandom), NB'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mux_2to1_sel.md
Name: mux_2to1_sel

Overview:
- 32-bit (parameterisable) two-input word selector for datapath operand steering, e.g. ALU source or write-back select.
- `i_selector` = 0 forwards `i_entradaMUX_0`; 1 forwards `i_entradaMUX_1`.
- Optional output register; valid flag travels alongside the data.
- Sits between register-file/immediate sources and consumers inside a pipeline stage.

Parameters:
- NB_DATA, 32: width of each data input and of the output.
- REGISTERED, 1: 1 = output registered, 1-cycle latency; 0 = purely combinational output.

Ports:
- i_clk  input  1  system clock, rising-edge active.
- i_rst_n  input  1  asynchronous active-low reset.
- i_enable  input  1  output register load enable; ignored when REGISTERED=0.
- i_valid  input  1  data inputs qualified this cycle.
- i_selector  input  1  0 selects input 0, 1 selects input 1.
- i_entradaMUX_0  input  NB_DATA  data input 0.
- i_entradaMUX_1  input  NB_DATA  data input 1.
- o_salidaMUX  output  NB_DATA  selected data.
- o_valid  output  1  o_salidaMUX qualified.

Behaviour:
- One clock (i_clk); reset asynchronous, active-low (i_rst_n). Assertion takes effect immediately, not at a clock edge. Deassertion is synchronised externally.
- Select function: sel_data = i_selector ? i_entradaMUX_1 : i_entradaMUX_0. Full NB_DATA width, no truncation or extension.
- Unknown selector: if i_selector is X/Z, the output is X in simulation. No default leg is forced. The bench must drive the selector before sampling.
- REGISTERED=1:
  - On each rising edge with i_enable=1: o_salidaMUX <= sel_data, o_valid <= i_valid.
  - With i_enable=0: both hold their previous values.
  - Latency exactly 1 cycle, throughput 1 word/cycle.
- REGISTERED=0:
  - o_salidaMUX = sel_data combinationally; o_valid = i_valid.
  - No clocked state except the optional-feature counter.
- Reset values: o_salidaMUX = 0, o_valid = 0 while i_rst_n=0 (REGISTERED=1). In REGISTERED=0 mode outputs follow inputs even during reset, except the optional counter.
- Reset mid-operation: the register clears asynchronously. The first post-reset load occurs at the first rising edge with i_rst_n=1 and i_enable=1.
- Simultaneous events: selector and data changing in the same cycle are sampled together; the new selector picks among the new data.
- i_valid=0: data is still passed and registered. Only o_valid marks it unqualified; data is not gated to zero.

Optional Feature:
- Macro: MUX_SEL_STATS_EN.
- Defined:
  - Adds output o_sel_toggles [15:0], a count of rising clock edges on which i_valid=1 and i_selector differs from its value at the previous such edge.
  - The counter saturates at 16'hFFFF and resets to 0 asynchronously on i_rst_n=0.
  - The previous-selector register resets to 0.
  - The counter is present in both REGISTERED modes.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package: NB_DATA default (32), the SEL_IN0=1'b0 / SEL_IN1=1'b1 constants, and the counter width constant (16).
- One natural sub-module: out_reg, a NB_DATA+1-bit enable register with async active-low clear. It is instantiated only under REGISTERED=1 via a generate block.
- The selection logic stays in the top module.

Test Plan:
- Reset: assert i_rst_n=0 with inputs 0xfff000aa/0xffffffff -> o_salidaMUX=0, o_valid=0 immediately, without waiting for a clock edge.
- Select 0 (REGISTERED=1): i_entradaMUX_0=0xfff000aa, i_entradaMUX_1=0xffffffff, selector=0, valid=1, enable=1 -> 0xfff000aa and o_valid=1 one cycle later.
- Toggle sequence: selector 0→1→0, each held for 2 cycles -> output 0xfff000aa, 0xffffffff, 0xfff000aa, each lagging the selector by exactly 1 cycle.
- Hold: enable=0 while selector switches to 1 -> output stays 0xfff000aa. Re-enable -> 0xffffffff next cycle.
- Combinational (REGISTERED=0): selector=1 -> output 0xffffffff within the same timestep; selector=0 -> 0xfff000aa.
- MUX_SEL_STATS_EN: 5 selector changes with valid=1, plus one change with valid=0 -> o_sel_toggles=5. Assert reset -> 0.
